// File: rtl/invaes_pkg.sv
// Shared AES definitions: FSM states, round constants and GF(2^8) byte/word/state transforms.
// S-boxes are derived arithmetically (field inverse plus affine map) instead of using lookup tables.
package invaes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero maps to zero as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 0; n < 7; n++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // State byte n (= 4*column + row) lives at bits [127-8n -: 8]
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[8*n +: 8] = inv ? inv_sbox(s[8*n +: 8]) : sbox(s[8*n +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (inv) o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
        else     o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = inv ? inv_mix_column(s[127-32*c -: 32]) : mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

endpackage

// File: rtl/invaes_core.sv
// clk-domain AES engine: captures a frame, expands the key one word per cycle,
// then runs one (inverse) round per cycle and holds the result until load rises.
module invaes_core import invaes_pkg::*; #(
  parameter int K = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [K+135:0] frame,
  output logic           done,
  output logic [127:0]   result
);
  localparam int NK = K / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);

  state_t        state_reg, state_next;
  logic [IW-1:0] i_reg;
  logic [2:0]    j_reg;
  logic [3:0]    rc_reg;
  logic [3:0]    r_reg;
  logic          dec_reg;
  logic          done_reg;
  logic [127:0]  st_reg;
  logic [127:0]  result_reg;
  logic [31:0]   w_reg [NW];

  logic [127:0]  rk_all [NR+1];
  logic [3:0]    kidx;
  logic [127:0]  rk;
  logic [31:0]   tmp;
  logic [31:0]   new_word;
  logic          last_round;
  logic [127:0]  enc_sr, enc_out, dec_ark, dec_out, round_out;

  generate
    for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
      assign rk_all[gi] = {w_reg[4*gi], w_reg[4*gi+1], w_reg[4*gi+2], w_reg[4*gi+3]};
    end
  endgenerate

  // j_reg tracks i mod Nk and rc_reg tracks i / Nk, avoiding a divider
  always_comb begin
    tmp = w_reg[i_reg - IW'(1)];
    if (j_reg == 3'd0)
      tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {RCON[rc_reg], 24'h000000};
    else if (NK > 6 && j_reg == 3'd4)
      tmp = sub_word(tmp);
    new_word = w_reg[i_reg - IW'(NK)] ^ tmp;
  end

  assign kidx       = dec_reg ? 4'(NR) - r_reg : r_reg;
  assign rk         = rk_all[kidx];
  assign last_round = (r_reg == 4'(NR));
  assign enc_sr     = shift_rows(sub_bytes(st_reg, 1'b0), 1'b0);
  assign enc_out    = (last_round ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ rk;
  assign dec_ark    = sub_bytes(shift_rows(st_reg, 1'b1), 1'b1) ^ rk;
  assign dec_out    = last_round ? dec_ark : mix_columns(dec_ark, 1'b1);
  assign round_out  = (r_reg == 4'd0) ? (st_reg ^ rk) : (dec_reg ? dec_out : enc_out);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!load) state_next = EXPAND;
      EXPAND:  if (load) state_next = IDLE;
               else if (i_reg == IW'(NW - 1)) state_next = ROUND;
      ROUND:   if (load) state_next = IDLE;
               else if (last_round) state_next = DONE;
      DONE:    if (load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      done_reg   <= 1'b0;
      result_reg <= '0;
      r_reg      <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      rc_reg     <= '0;
      dec_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: if (!load) begin
          st_reg  <= frame[K+135 -: 128];
          dec_reg <= |frame[7:0];
          for (int n = 0; n < NK; n++) w_reg[n] <= frame[K+7-32*n -: 32];
          i_reg   <= IW'(NK);
          j_reg   <= 3'd0;
          rc_reg  <= 4'd1;
          r_reg   <= 4'd0;
        end
        EXPAND: begin
          w_reg[i_reg] <= new_word;
          i_reg        <= i_reg + IW'(1);
          j_reg        <= (j_reg == 3'(NK - 1)) ? 3'd0 : j_reg + 3'd1;
          if (j_reg == 3'd0) rc_reg <= rc_reg + 4'd1;
        end
        ROUND: begin
          st_reg <= round_out;
          r_reg  <= r_reg + 4'd1;
        end
        DONE: begin
          result_reg <= st_reg;
          done_reg   <= !load;
        end
        default: ;
      endcase
    end
  end

  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: rtl/invaes_spi.sv
// Serial front end: sck-clocked frame shifter and result serializer around the clk-domain core.
// The host keeps sck quiet while it drops load, so the core samples a stable frame.
module invaes_spi #(
  parameter int K = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic sdi,
  input  logic load,
  output logic sdo,
  output logic done
);
  logic [K+135:0] shift_reg;
  logic [127:0]   out_reg;
  logic [127:0]   result;
  logic           wasdone;

  always_ff @(posedge sck) begin
    shift_reg <= {shift_reg[K+134:0], sdi};
  end

  // First pulse after done presents result[127] directly; later pulses walk out_reg
  always_ff @(negedge sck) begin
    wasdone <= done;
    if (!wasdone) out_reg <= {result[126:0], 1'b0};
    else          out_reg <= {out_reg[126:0], 1'b0};
  end

  assign sdo = wasdone ? out_reg[127] : result[127];

  invaes_core #(.K(K)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .frame  (shift_reg),
    .done   (done),
    .result (result)
  );

endmodule

// File: tb/tb_invaes_spi.sv
// Bench for invaes_spi: three instances (K=128/192/256) driven over the serial port,
// results checked against a scoreboard of known-answer vectors.
module tb_invaes_spi;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic [2:0] sdi_v = 3'b000;
  logic [2:0] load_v = 3'b111;
  wire  [2:0] sdo_v;
  wire  [2:0] done_v;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int           dut;
    string        tag;
    logic [127:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  invaes_spi #(.K(128)) u_dut128 (.clk(clk), .reset(reset), .sck(sck), .sdi(sdi_v[0]),
                                  .load(load_v[0]), .sdo(sdo_v[0]), .done(done_v[0]));
  invaes_spi #(.K(192)) u_dut192 (.clk(clk), .reset(reset), .sck(sck), .sdi(sdi_v[1]),
                                  .load(load_v[1]), .sdo(sdo_v[1]), .done(done_v[1]));
  invaes_spi #(.K(256)) u_dut256 (.clk(clk), .reset(reset), .sck(sck), .sdi(sdi_v[2]),
                                  .load(load_v[2]), .sdo(sdo_v[2]), .done(done_v[2]));

  localparam logic [255:0] KEY128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEYC1  = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic shift_bit(input int d, input logic b);
    sdi_v[d] = b;
    #3 sck = 1'b1;
    #6 sck = 1'b0;
    #4;
  endtask

  task automatic send_frame(input int d, input int kbits, input logic [255:0] key,
                            input logic [127:0] data, input logic [7:0] dir);
    load_v[d] = 1'b1;
    for (int n = 127; n >= 0; n--) shift_bit(d, data[n]);
    for (int n = kbits - 1; n >= 0; n--) shift_bit(d, key[n]);
    for (int n = 7; n >= 0; n--) shift_bit(d, dir[n]);
  endtask

  // cyc counts clk edges after the one that first samples load low
  task automatic start_and_wait(input int d, output int cyc, output bit ok);
    @(negedge clk);
    load_v[d] = 1'b0;
    @(posedge clk);
    cyc = 0;
    ok = 1'b0;
    while (cyc < 200 && !ok) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done_v[d]) ok = 1'b1;
    end
  endtask

  task automatic read_result(input int d, output logic [127:0] r);
    for (int n = 127; n >= 0; n--) begin
      #3 sck = 1'b1;
      #3 r[n] = sdo_v[d];
      #4 sck = 1'b0;
      #3;
    end
  endtask

  task automatic run_txn(input int d, input int kbits, input logic [255:0] key,
                         input logic [127:0] data, input logic [7:0] dir,
                         input logic [127:0] exp, input string tag, output int cyc);
    bit           ok;
    logic [127:0] got;
    sb_t          e;
    send_frame(d, kbits, key, data, dir);
    sb_q.push_back('{dut: d, tag: tag, exp: exp});
    start_and_wait(d, cyc, ok);
    e = sb_q.pop_front();
    if (!ok) begin
      check_eq({e.tag, "_timeout"}, 128'(done_v[d]), 128'd1);
      $display("TXN %s dut=%0d timed out", e.tag, e.dut);
    end else begin
      read_result(d, got);
      check_eq(e.tag, got, e.exp);
      $display("TXN %s dut=%0d dir=%02h cycles=%0d result=%h", e.tag, e.dut, dir, cyc, got);
    end
    load_v[d] = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic watch_done_low(input int d, input int ncyc, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (done_v[d]) seen = 1'b1;
    end
    check_eq(tag, 128'(seen), 128'd0);
    $display("TXN %s dut=%0d done_seen=%0d", tag, d, seen);
  endtask

  initial begin
    int  cyc;
    bit  ok;
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_eq($sformatf("reset_done%0d", d), 128'(done_v[d]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_txn(0, 128, KEY128, PT1, 8'h00, CT1, "k128_enc", cyc);
    check_eq("k128_latency", 128'(cyc), 128'd52);
    run_txn(0, 128, KEY128, CT1, 8'h01, PT1, "k128_dec", cyc);
    run_txn(0, 128, KEYC1, PT2, 8'h00, CTC1, "k128_c1_enc", cyc);
    run_txn(1, 192, KEY192, PT2, 8'h00, CT192, "k192_enc", cyc);
    run_txn(1, 192, KEY192, CT192, 8'hff, PT2, "k192_dec", cyc);
    run_txn(2, 256, KEY256, PT2, 8'h00, CT256, "k256_enc", cyc);
    run_txn(2, 256, KEY256, CT256, 8'h80, PT2, "k256_dec", cyc);

    // load raised partway through the round sequence
    send_frame(0, 128, KEYC1, PT2, 8'h00);
    @(negedge clk);
    load_v[0] = 1'b0;
    repeat (46) @(posedge clk);
    @(negedge clk);
    load_v[0] = 1'b1;
    watch_done_low(0, 60, "abort_done");
    run_txn(0, 128, KEYC1, CTC1, 8'h01, PT2, "abort_reload", cyc);

    // reset while expanding the key
    send_frame(0, 128, KEY128, PT1, 8'h00);
    @(negedge clk);
    load_v[0] = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    load_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_expand_done", 128'(done_v[0]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_done_low(0, 60, "rst_expand_quiet");
    run_txn(0, 128, KEY128, PT1, 8'h00, CT1, "rst_reload", cyc);

    // reset while holding a result whose MSB is one: done drops and result clears
    send_frame(1, 192, KEY192, PT2, 8'h00);
    start_and_wait(1, cyc, ok);
    check_eq("rst_pre_done", 128'(ok), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_done", 128'(done_v[1]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    load_v[1] = 1'b1;
    @(posedge clk);
    shift_bit(1, 1'b0);
    check_eq("rst_result_msb", 128'(sdo_v[1]), 128'd0);
    $display("TXN rst_in_done dut=1 done=%0d sdo=%0d", done_v[1], sdo_v[1]);

    check_eq("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/invaes_spi.md
INVAES_SPI -- requirements
Module: invaes

Interface
REQ-001 Parameter K, default 256: cipher key width in bits; legal values 128, 192, 256; Nk = K/32, Nr = 10/12/14 respectively.
REQ-002 clk  input  1: sole core clock; all core state updates on its rising edge.
REQ-003 reset  input  1: reset is synchronous and active-high.
REQ-004 sck  input  1: serial clock, asynchronous to clk; clocks only the serial shift registers.
REQ-005 sdi  input  1: serial data in, sampled on sck rising edge.
REQ-006 load  input  1: high while host loads a frame; falling level starts the operation.
REQ-007 sdo  output  1: serial result out, MSB first.
REQ-008 done  output  1: high when the result is valid.

Function
REQ-009 Input frame shall be K+136 bits, MSB first: 128-bit data block, then K-bit key, then 8-bit direction byte.
REQ-010 Input shift register shall shift left, sdi into the LSB, on every sck rising edge, independent of load and done.
REQ-011 Direction byte 0x00 shall select encryption (FIPS-197 Cipher); any nonzero value shall select decryption (InvCipher).
REQ-012 While load is high, the core shall be in IDLE with done low; on each clk edge where load is low in IDLE, the core shall capture data, key and direction and enter EXPAND.
REQ-013 EXPAND: W[0..Nk-1] = key words; one further word W[i] per clk cycle per the FIPS-197 KeyExpansion (RotWord/SubWord/Rcon when i mod Nk = 0; SubWord only when Nk = 8 and i mod 8 = 4) until W[4Nr+3]; i.e. 40/46/52 cycles for K = 128/192/256.
REQ-014 All 4(Nr+1) words shall be kept in a register array so decryption can read round keys in reverse order.
REQ-015 ROUND: Nr+1 clk cycles; cycle 0 AddRoundKey; cycles 1..Nr-1 full round; cycle Nr final round without (Inv)MixColumns.
REQ-016 Encryption round order: SubBytes, ShiftRows, MixColumns, AddRoundKey(r). Decryption: InvShiftRows, InvSubBytes, AddRoundKey(Nr-r), InvMixColumns; first AddRoundKey uses key Nr, last uses key 0.
REQ-017 After the final round, the state shall go to DONE, latch the 128-bit result and assert done on the next cycle; done shall stay high until load goes high.
REQ-018 load rising during EXPAND or ROUND shall abort and return to IDLE on the next clk edge with done low.
REQ-019 Byte order: state byte 0 is data bits [127:120], column-major per FIPS-197.
REQ-020 Output path: flag wasdone, updated on sck falling edge to done; sdo = wasdone ? outreg[127] : result[127].
REQ-021 On each sck falling edge: if wasdone is low, outreg <= {result[126:0], 0}; otherwise outreg shifts left by one; host samples sdo while sck is high, 128 pulses.

Reset
REQ-022 On reset: state IDLE, done low, result and round counter zero; sck-domain registers (input shift, outreg, wasdone) are not reset.
REQ-023 Reset shall take priority over load and any in-progress operation.

Structure
REQ-024 Package invaes_pkg shall hold the state enum (IDLE, EXPAND, ROUND, DONE), the Rcon table, and functions for SubWord/S-box, inverse S-box, xtime, MixColumns and InvMixColumns.
REQ-025 The S-box and inverse S-box shall be computed as GF(2^8) inverse plus the affine transform (no 256-entry tables).
REQ-026 One sub-module, invaes_core (clk-domain FSM, key expansion, rounds); the top holds the sck-domain shift logic.

Verification
REQ-027 K=128, dir 0x00, key 2B7E151628AED2A6ABF7158809CF4F3C, data 3243F6A8885A308D313198A2E0370734 -> 3925841D02DC09FBDC118597196A0B32.
REQ-028 K=128, dir 0x01, same key, data 3925841D02DC09FBDC118597196A0B32 -> 3243F6A8885A308D313198A2E0370734.
REQ-029 K=192, key 000102...1617, dir 0x00, data 00112233445566778899AABBCCDDEEFF -> DDA97CA4864CDFE06EAF70A0EC0D7191; dir 0xFF inverts it.
REQ-030 K=256, key 000102...1E1F, dir 0x00, data 00112233445566778899AABBCCDDEEFF -> 8EA2B7CA516745BFEAFC49904B496089; dir 0x80 inverts it.
REQ-031 K=128 encrypt: done rises exactly 40+11+1 clk cycles after load is sampled low; load raised mid-ROUND -> done stays low; a reloaded frame then produces the correct result.
REQ-032 Assert reset during EXPAND -> done low next cycle; a subsequent full frame produces the correct result.
